// File: rtl/dmem_ls_arbiter_pkg.sv
// rv32i_types: shared state encoding and constants for the dmem load/store arbiter.
package rv32i_types;
    typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT, DRAIN} dmem_arb_state_t;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFFFFFC;
endpackage

// File: rtl/dmem_ls_arbiter.sv
// dmem_ls_arbiter: arbitrates load_rs reads and store_rs writes onto a single-outstanding dmem port.
// DMEM_ROUND_ROBIN_EN: alternate priority between classes when both request.
module dmem_ls_arbiter
    import rv32i_types::*;
#(
    parameter int LOAD_RS_DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     move_flush,
    input  logic                     dmem_r_rqst,
    input  logic [LOAD_RS_DEPTH-1:0] load_rs_idx_rqst,
    input  logic [31:0]              arbiter_load_rs_addr,
    input  logic [3:0]               arbiter_load_rs_rmask,
    input  logic                     store_w_rqst,
    input  logic [31:0]              arbiter_store_rs_addr,
    input  logic [3:0]               arbiter_store_rs_wmask,
    input  logic [31:0]              arbiter_store_rs_wdata,
    output logic                     load_rs_pop,
    output logic [LOAD_RS_DEPTH-1:0] load_rs_idx_executing,
    output logic [31:0]              dmem_rdata,
    output logic                     store_rs_pop,
    output logic [31:0]              dmem_addr,
    output logic [3:0]               dmem_rmask,
    output logic [3:0]               dmem_wmask,
    output logic [31:0]              dmem_wdata,
    input  logic [31:0]              dmem_resp_rdata,
    input  logic                     dmem_resp
);
    dmem_arb_state_t          state;
    logic [LOAD_RS_DEPTH-1:0] idx_q;
    logic                     post_rst;
    logic                     idle, load_ok, pick_store, grant_store, grant_load;
`ifdef DMEM_ROUND_ROBIN_EN
    logic                     last_grant;
`endif
    // the cycle right after reset is kept silent, so no grant is taken there
    always_comb begin
        idle        = !rst && !post_rst && state == IDLE;
        load_ok     = dmem_r_rqst && !move_flush;
`ifdef DMEM_ROUND_ROBIN_EN
        pick_store  = !load_ok || !last_grant;
`else
        pick_store  = 1'b1;
`endif
        grant_store = idle && store_w_rqst && pick_store;
        grant_load  = idle && load_ok && !grant_store;
        dmem_addr   = grant_store ? arbiter_store_rs_addr & WORD_ALIGN_MASK :
                      grant_load  ? arbiter_load_rs_addr & WORD_ALIGN_MASK : '0;
        dmem_wmask  = grant_store ? arbiter_store_rs_wmask : '0;
        dmem_wdata  = grant_store ? arbiter_store_rs_wdata : '0;
        dmem_rmask  = grant_load ? arbiter_load_rs_rmask : '0;
        load_rs_pop = !rst && state == LOAD_WAIT && dmem_resp && !move_flush;
        dmem_rdata  = load_rs_pop ? dmem_resp_rdata : '0;
        store_rs_pop = !rst && state == STORE_WAIT && dmem_resp;
        load_rs_idx_executing = rst ? '0 : idx_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx_q    <= '0;
            post_rst <= 1'b1;
`ifdef DMEM_ROUND_ROBIN_EN
            last_grant <= 1'b0;
`endif
        end else begin
            post_rst <= 1'b0;
`ifdef DMEM_ROUND_ROBIN_EN
            if (grant_store || grant_load) last_grant <= grant_store;
`endif
            case (state)
                IDLE: begin
                    if (grant_store) state <= STORE_WAIT;
                    else if (grant_load) begin
                        state <= LOAD_WAIT;
                        idx_q <= load_rs_idx_rqst;
                    end
                end
                LOAD_WAIT:  state <= dmem_resp ? IDLE : move_flush ? DRAIN : LOAD_WAIT;
                STORE_WAIT: state <= dmem_resp ? IDLE : STORE_WAIT;
                DRAIN:      state <= dmem_resp ? IDLE : DRAIN;
            endcase
        end
    end
endmodule
